// File: rtl/router_pkg.sv
// Shared constants and encodings for the router output-port-lookup datapath.
package router_pkg;

    localparam int unsigned DstMacPos = 208;
    localparam int unsigned SrcMacPos = 160;
    localparam int unsigned TtlPos    = 72;
    localparam int unsigned CsumPos   = 48;

    localparam logic [7:0] Port0 = 8'h01;
    localparam logic [7:0] Port1 = 8'h04;
    localparam logic [7:0] Port2 = 8'h10;
    localparam logic [7:0] Port3 = 8'h40;
    localparam logic [7:0] Cpu0  = 8'h02;
    localparam logic [7:0] Cpu1  = 8'h08;
    localparam logic [7:0] Cpu2  = 8'h20;
    localparam logic [7:0] Cpu3  = 8'h80;

    typedef enum logic [0:0] {StIdle, StPayload} state_e;
    typedef enum logic [1:0] {DecPass, DecFwd, DecTtl, DecMiss} dec_e;

    // Each physical port's CPU queue sits one bit above it in the one-hot map.
    function automatic logic [7:0] cpu_queue(logic [7:0] src);
        return (src & 8'h55) << 1;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small input FIFO: a ring buffer followed by a prefetch register that presents the head.
module fallthrough_small_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [Width-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(Depth);
    localparam logic [PtrW:0] NearFull = (PtrW + 1)'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] head_q;
    logic             head_valid_q;
    logic             ring_wr, ring_rd;

    assign ring_wr = wr_en && (count_q != Full);
    assign ring_rd = (count_q != '0) && (!head_valid_q || rd_en);

    always_comb begin
        count_d = count_q;
        if (ring_wr && !ring_rd) count_d = count_q + 1'b1;
        else if (!ring_wr && ring_rd) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (ring_wr) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (ring_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (ring_rd) begin
                rd_ptr_q     <= rd_ptr_q + PtrW'(1);
                head_q       <= mem_q[rd_ptr_q];
                head_valid_q <= 1'b1;
            end else if (rd_en) begin
                head_valid_q <= 1'b0;
            end
        end
    end

    assign dout        = head_q;
    assign empty       = !head_valid_q;
    assign nearly_full = count_q >= NearFull;

endmodule

// File: rtl/ip_header_rewrite.sv
// Rewrites Ethernet/IPv4 headers of forwarded packets after ARP lookup and steers
// exceptions to the ingress port's CPU queue.
module ip_header_rewrite
    import router_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned SRC_PORT_POS         = 16,
    parameter int unsigned DST_PORT_POS         = 24
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    input  logic                                arp_hit,
    input  logic [47:0]                         dest_mac,
    input  logic [31:0]                         oq_in,
    input  logic [47:0]                         mac0,
    input  logic [47:0]                         mac1,
    input  logic [47:0]                         mac2,
    input  logic [47:0]                         mac3,
    input  logic                                counter_clear,
    output logic [31:0]                         pkt_forwarded,
    output logic [31:0]                         pkt_to_cpu,
    output logic [31:0]                         ttl_expired
);

    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned FifoW = DW + SW + UW + 1;

    logic [FifoW-1:0] fifo_dout;
    logic             fifo_empty, fifo_nearly_full, pop;
    logic [DW-1:0]    head_tdata;
    logic [SW-1:0]    head_tstrb;
    logic [UW-1:0]    head_tuser;
    logic             head_tlast;

    fallthrough_small_fifo #(
        .Width (FifoW),
        .Depth (4)
    ) u_in_fifo (
        .clk         (AXI_ACLK),
        .rst         (AXI_RESET),
        .din         ({S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA}),
        .wr_en       (S_AXIS_TVALID && S_AXIS_TREADY),
        .rd_en       (pop),
        .dout        (fifo_dout),
        .empty       (fifo_empty),
        .nearly_full (fifo_nearly_full)
    );

    assign {head_tlast, head_tuser, head_tstrb, head_tdata} = fifo_dout;
    assign S_AXIS_TREADY = !fifo_nearly_full && !AXI_RESET;

    state_e           state_q, state_d;
    dec_e             dec_new;
    logic [7:0]       dst_q, dst_new, head_dst, head_src;
    logic [7:0]       ttl;
    logic [15:0]      csum, csum_new;
    logic [16:0]      csum_sum;
    logic [47:0]      port_mac;
    logic             oq_valid, first_pop;
    logic             out_valid_q, out_last_q;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]    out_strb_q;
    logic [UW-1:0]    out_user_q, out_user_d;
    logic [31:0]      fwd_cnt_q, cpu_cnt_q, ttl_cnt_q;
    logic             unused_oq;

    assign unused_oq = ^oq_in[31:8];
    assign pop       = !fifo_empty && (!out_valid_q || M_AXIS_TREADY);
    assign first_pop = pop && (state_q == StIdle);
    assign head_dst  = head_tuser[DST_PORT_POS +: 8];
    assign head_src  = head_tuser[SRC_PORT_POS +: 8];
    assign ttl       = head_tdata[TtlPos +: 8];
    assign csum      = head_tdata[CsumPos +: 16];
    // Incremental update for TTL-1: add 0x0100 in ones' complement.
    assign csum_sum  = {1'b0, csum} + 17'h00100;
    assign csum_new  = csum_sum[15:0] + {15'b0, csum_sum[16]};

    always_comb begin
        oq_valid = 1'b1;
        port_mac = mac0;
        case (oq_in[7:0])
            Port0:   port_mac = mac0;
            Port1:   port_mac = mac1;
            Port2:   port_mac = mac2;
            Port3:   port_mac = mac3;
            default: oq_valid = 1'b0;
        endcase
    end

    always_comb begin
        if (head_dst != 8'h00)                       dec_new = DecPass;
        else if (arp_hit && oq_valid && ttl > 8'd1)  dec_new = DecFwd;
        else if (arp_hit && oq_valid)                dec_new = DecTtl;
        else                                         dec_new = DecMiss;
        unique case (dec_new)
            DecPass: dst_new = head_dst;
            DecFwd:  dst_new = oq_in[7:0];
            default: dst_new = cpu_queue(head_src);
        endcase
    end

    always_comb begin
        out_data_d = head_tdata;
        out_user_d = head_tuser;
        if (state_q == StIdle) begin
            out_user_d[DST_PORT_POS +: 8] = dst_new;
            if (dec_new == DecFwd) begin
                out_data_d[DstMacPos +: 48] = dest_mac;
                out_data_d[SrcMacPos +: 48] = port_mac;
                out_data_d[TtlPos +: 8]     = ttl - 8'd1;
                out_data_d[CsumPos +: 16]   = csum_new;
            end
        end else begin
            out_user_d[DST_PORT_POS +: 8] = dst_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pop && !head_tlast) state_d = StPayload;
            StPayload: if (pop && head_tlast)  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state_q     <= StIdle;
            dst_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_user_q  <= '0;
        end else begin
            state_q <= state_d;
            if (first_pop) dst_q <= dst_new;
            if (pop) begin
                out_valid_q <= 1'b1;
                out_last_q  <= head_tlast;
                out_data_q  <= out_data_d;
                out_strb_q  <= head_tstrb;
                out_user_q  <= out_user_d;
            end else if (M_AXIS_TREADY) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            fwd_cnt_q <= '0;
            cpu_cnt_q <= '0;
            ttl_cnt_q <= '0;
        end else if (counter_clear) begin
            fwd_cnt_q <= '0;
            cpu_cnt_q <= '0;
            ttl_cnt_q <= '0;
        end else if (first_pop) begin
            if (dec_new == DecFwd)  fwd_cnt_q <= fwd_cnt_q + 32'd1;
            if (dec_new == DecMiss) cpu_cnt_q <= cpu_cnt_q + 32'd1;
            if (dec_new == DecTtl)  ttl_cnt_q <= ttl_cnt_q + 32'd1;
        end
    end

    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TLAST  = out_last_q;
    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TSTRB  = out_strb_q;
    assign M_AXIS_TUSER  = out_user_q;
    assign pkt_forwarded = fwd_cnt_q;
    assign pkt_to_cpu    = cpu_cnt_q;
    assign ttl_expired   = ttl_cnt_q;

endmodule
